// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural fetch PC, keeps at most one imem request
// in flight and hands each returned word to decode, squashing wrong-path fetches on redirect.
module fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            resolve_valid,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]      if_pc_q, if_pc_d;
  logic                 fault_q, fault_d;
  logic [XLEN-1:0]      fault_addr_q, fault_addr_d;

  logic                 redirect;
  logic [XLEN-1:0]      tgt;
  logic                 tgt_misaligned;

  // Branch resolution decode; jalr target has bit0 forced to zero.
  always_comb begin
    redirect       = resolve_valid & ((pc_src == 2'b01) | (pc_src == 2'b10));
    tgt            = (pc_src == 2'b01) ? br_target : (jalr_target & ~XLEN'(1));
    tgt_misaligned = tgt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      instr_q      <= '0;
      if_pc_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      instr_q      <= instr_d;
      if_pc_q      <= if_pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    instr_d      = instr_q;
    if_pc_d      = if_pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) fetch_pc_d = tgt;
      end
      S_REQ: begin
        if (redirect) fetch_pc_d = tgt;
        if (imem_req_ready) state_d = redirect ? S_DRAIN : S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (redirect) begin
          // A response arriving with the redirect is wrong-path and simply dropped.
          fetch_pc_d = tgt;
          state_d    = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          state_d    = S_HOLD;
          instr_d    = imem_rsp_data;
          if_pc_d    = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_pc_d = tgt;
          state_d    = S_REQ;
        end else if (if_ready) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = tgt;
        if (imem_rsp_valid) state_d = S_REQ;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A misaligned redirect target overrides everything and parks the sequencer.
    if ((state_q != S_FAULT) && redirect && tgt_misaligned) begin
      state_d      = S_FAULT;
      fetch_pc_d   = fetch_pc_q;
      fault_d      = 1'b1;
      fault_addr_d = tgt;
    end
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_addr      = fetch_pc_q;
    if_valid       = (state_q == S_HOLD) & ~redirect;
    if_instr       = instr_q;
    if_pc          = if_pc_q;
    fault          = fault_q;
    fault_addr     = fault_addr_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, redirects, stall, fault and PC wrap.
module tb_fetch_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            resolve_valid;
  logic [1:0]      pc_src;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_ready;

  logic            imem_req_valid, if_valid, fault;
  logic [XLEN-1:0] imem_addr, if_pc, fault_addr;
  logic [31:0]     if_instr;

  logic            w_req_valid, w_if_valid, w_fault;
  logic [XLEN-1:0] w_addr, w_if_pc, w_fault_addr;
  logic [31:0]     w_if_instr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .resolve_valid(resolve_valid), .pc_src(pc_src),
    .br_target(br_target), .jalr_target(jalr_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fault(fault), .fault_addr(fault_addr)
  );

  fetch_sequencer #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .resolve_valid(resolve_valid), .pc_src(pc_src),
    .br_target(br_target), .jalr_target(jalr_target),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(w_if_valid), .if_ready(if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc),
    .fault(w_fault), .fault_addr(w_fault_addr)
  );

  task automatic idle_inputs();
    resolve_valid  = 1'b0;
    pc_src         = 2'b00;
    br_target      = '0;
    jalr_target    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_regs got=%h/%h exp=0/0", if_instr, if_pc); end
    checks++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin failures++; $display("FAIL rst_fault got=%b/%h exp=0/0", fault, fault_addr); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_req got=%b exp=0", imem_req_valid); end
  endtask

  // T1: three sequential fetches, 3 cycles each.
  task automatic test_seq_fetch();
    logic [31:0] exp_pc;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(4 * k);
      next_cycle();
      idle_inputs();
      imem_req_ready = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL t1_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_addr, exp_pc); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL t1_req_ifv k=%0d got=%b exp=0", k, if_valid); end
      next_cycle();
      idle_inputs();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hA000 + 32'(k);
      #1;
      checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL t1_wait k=%0d got=%b/%b exp=0/0", k, imem_req_valid, if_valid); end
      next_cycle();
      idle_inputs();
      if_ready = 1'b1;
      #1;
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL t1_ifv k=%0d got=%b exp=1", k, if_valid); end
      checks++; if (if_instr !== (32'hA000 + 32'(k)) || if_pc !== exp_pc) begin failures++; $display("FAIL t1_instr k=%0d got=%h/%h exp=%h/%h", k, if_instr, if_pc, 32'hA000 + 32'(k), exp_pc); end
    end
  endtask

  // T2: branch redirect while waiting; following response must be dropped.
  task automatic test_redirect_wait();
    next_cycle();
    idle_inputs();
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'hC || imem_req_valid !== 1'b1) begin failures++; $display("FAIL t2_req got=%b/%h exp=1/0000000c", imem_req_valid, imem_addr); end
    next_cycle();
    idle_inputs();
    resolve_valid = 1'b1;
    pc_src        = 2'b01;
    br_target     = 32'h100;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("FAIL t2_drain got=%b/%h exp=0/00000100", imem_req_valid, imem_addr); end
    next_cycle();
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL t2_drain2 got=%b/%b exp=0/0", imem_req_valid, if_valid); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL t2_newreq got=%b/%h exp=1/00000100", imem_req_valid, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'hA002) begin failures++; $display("FAIL t2_dropped got=%b/%h exp=0/0000a002", if_valid, if_instr); end
  endtask

  // T3: jalr redirect in HOLD masks if_valid; then pc_src=11 and REQ-stall redirect.
  task automatic test_redirect_hold();
    imem_req_ready = 1'b1;
    next_cycle();
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hB100;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hB100) begin failures++; $display("FAIL t3_hold got=%b/%h/%h exp=1/00000100/0000b100", if_valid, if_pc, if_instr); end
    resolve_valid = 1'b1;
    pc_src        = 2'b10;
    jalr_target   = 32'h201;
    if_ready      = 1'b1;
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL t3_mask got=%b exp=0", if_valid); end
    next_cycle();
    idle_inputs();
    resolve_valid = 1'b1;
    pc_src        = 2'b11;
    br_target     = 32'h300;
    jalr_target   = 32'h400;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL t3_jalr got=%b/%h exp=1/00000200", imem_req_valid, imem_addr); end
    next_cycle();
    idle_inputs();
    resolve_valid = 1'b1;
    pc_src        = 2'b01;
    br_target     = 32'h180;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL t3_src11 got=%b/%h exp=1/00000200", imem_req_valid, imem_addr); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h180) begin failures++; $display("FAIL t3_req_redir got=%b/%h exp=1/00000180", imem_req_valid, imem_addr); end
  endtask

  // T6: decode stalls 5 cycles in HOLD.
  task automatic test_hold_stall();
    imem_req_ready = 1'b1;
    next_cycle();
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hC180;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'hC180 || if_pc !== 32'h180) begin failures++; $display("FAIL t6_stall i=%0d got=%b/%h/%h exp=1/0000c180/00000180", i, if_valid, if_instr, if_pc); end
      checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL t6_noreq i=%0d got=%b exp=0", i, imem_req_valid); end
      next_cycle();
      idle_inputs();
    end
    if_ready = 1'b1;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h184) begin failures++; $display("FAIL t6_next got=%b/%h exp=1/00000184", imem_req_valid, imem_addr); end
  endtask

  // T4: misaligned branch target faults; only reset clears it.
  task automatic test_fault();
    resolve_valid = 1'b1;
    pc_src        = 2'b01;
    br_target     = 32'h102;
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (fault !== 1'b1 || fault_addr !== 32'h102) begin failures++; $display("FAIL t4_fault got=%b/%h exp=1/00000102", fault, fault_addr); end
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      checks++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || fault !== 1'b1) begin failures++; $display("FAIL t4_parked i=%0d got=%b/%b/%b exp=0/0/1", i, imem_req_valid, if_valid, fault); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin failures++; $display("FAIL t4_clear got=%b/%h exp=0/0", fault, fault_addr); end
  endtask

  // T5: reset PC at the top of the address space wraps to 0.
  task automatic test_wrap();
    test_reset();
    next_cycle();
    idle_inputs();
    imem_req_ready = 1'b1;
    #1;
    checks++; if (w_req_valid !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL t5_first got=%b/%h exp=1/fffffffc", w_req_valid, w_addr); end
    next_cycle();
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111;
    next_cycle();
    idle_inputs();
    if_ready = 1'b1;
    #1;
    checks++; if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_instr !== 32'h1111) begin failures++; $display("FAIL t5_hold got=%b/%h/%h exp=1/fffffffc/00001111", w_if_valid, w_if_pc, w_if_instr); end
    next_cycle();
    idle_inputs();
    #1;
    checks++; if (w_req_valid !== 1'b1 || w_addr !== 32'h0) begin failures++; $display("FAIL t5_wrap got=%b/%h exp=1/00000000", w_req_valid, w_addr); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_redirect_wait();
    test_redirect_hold();
    test_hold_stall();
    test_fault();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
